// File: rtl/cpumc_bus_arbiter.sv
// Request/grant arbiter for the CPU memory bus: rp2a03 (default), hci debugger, SD loader.
// Optional stall-cycle statistics are compiled in with CPUMC_ARB_STATS_EN.
module cpumc_bus_arbiter #(
    parameter int LDR_MAX_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [15:0]      cpu_a_in,
    input  logic             cpu_r_nw_in,
    input  logic [7:0]       cpu_d_in,
    output logic [7:0]       cpu_d_out,
    output logic             cpu_rdy_out,
    input  logic             hci_req_in,
    output logic             hci_gnt_out,
    input  logic [15:0]      hci_a_in,
    input  logic             hci_r_nw_in,
    input  logic [7:0]       hci_d_in,
    output logic [7:0]       hci_d_out,
    input  logic             ldr_req_in,
    output logic             ldr_gnt_out,
    input  logic [15:0]      ldr_a_in,
    input  logic             ldr_r_nw_in,
    input  logic [7:0]       ldr_d_in,
    output logic [7:0]       ldr_d_out,
    input  logic [7:0]       mem_d_in,
    output logic [15:0]      mem_a_out,
    output logic             mem_r_nw_out,
    output logic [7:0]       mem_d_out,
    output logic [1:0]       owner_out,
    output logic [CNT_W-1:0] stall_cnt_out
);

    // Encoding doubles as the owner_out code.
    typedef enum logic [1:0] {
        ST_CPU  = 2'd0,
        ST_HCI  = 2'd1,
        ST_LDR  = 2'd2,
        ST_TURN = 2'd3
    } state_t;

    localparam int TEN_W = $clog2(LDR_MAX_CYCLES + 1);
    localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'(LDR_MAX_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [TEN_W-1:0] r_tenure;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= ST_CPU;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Counts loader cycles spent while hci is waiting; cleared whenever hci is not waiting.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tenure <= '0;
        end else if (r_state == ST_LDR && hci_req_in && w_state_next == ST_LDR) begin
            r_tenure <= r_tenure + TEN_W'(1);
        end else begin
            r_tenure <= '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_a_out    = cpu_a_in;
        mem_r_nw_out = cpu_r_nw_in;
        mem_d_out    = cpu_d_in;
        cpu_d_out    = 8'h00;
        hci_d_out    = 8'h00;
        ldr_d_out    = 8'h00;
        cpu_rdy_out  = 1'b0;
        hci_gnt_out  = 1'b0;
        ldr_gnt_out  = 1'b0;
        case (r_state)
            ST_CPU: begin
                cpu_rdy_out = 1'b1;
                cpu_d_out   = mem_d_in;
                if (hci_req_in || ldr_req_in) begin
                    w_state_next = ST_TURN;
                end
            end
            ST_TURN: begin
                // Dead bus cycle: a read of address 0 so nobody can write.
                mem_a_out    = 16'h0000;
                mem_r_nw_out = 1'b1;
                mem_d_out    = 8'h00;
                if (hci_req_in) begin
                    w_state_next = ST_HCI;
                end else if (ldr_req_in) begin
                    w_state_next = ST_LDR;
                end else begin
                    w_state_next = ST_CPU;
                end
            end
            ST_HCI: begin
                hci_gnt_out  = 1'b1;
                hci_d_out    = mem_d_in;
                mem_a_out    = hci_a_in;
                mem_r_nw_out = hci_r_nw_in;
                mem_d_out    = hci_d_in;
                if (!hci_req_in) begin
                    w_state_next = ST_TURN;
                end
            end
            ST_LDR: begin
                ldr_gnt_out  = 1'b1;
                ldr_d_out    = mem_d_in;
                mem_a_out    = ldr_a_in;
                mem_r_nw_out = ldr_r_nw_in;
                mem_d_out    = ldr_d_in;
                if (!ldr_req_in || (hci_req_in && r_tenure == TEN_LAST)) begin
                    w_state_next = ST_TURN;
                end
            end
            default: w_state_next = ST_CPU;
        endcase
    end

    assign owner_out = r_state;

`ifdef CPUMC_ARB_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_stall_cnt <= '0;
        end else if (r_state != ST_CPU && r_stall_cnt != {CNT_W{1'b1}}) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_out = r_stall_cnt;
`else
    assign stall_cnt_out = '0;
`endif

endmodule

// File: tb/tb_cpumc_bus_arbiter.sv
// Randomized and directed bench for cpumc_bus_arbiter against an ownership-level reference model.
module tb_cpumc_bus_arbiter;

    localparam int LDR_MAX = 8;
    localparam int CNT_W   = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [15:0]      cpu_a_in;
    logic             cpu_r_nw_in;
    logic [7:0]       cpu_d_in;
    logic [7:0]       cpu_d_out;
    logic             cpu_rdy_out;
    logic             hci_req_in;
    logic             hci_gnt_out;
    logic [15:0]      hci_a_in;
    logic             hci_r_nw_in;
    logic [7:0]       hci_d_in;
    logic [7:0]       hci_d_out;
    logic             ldr_req_in;
    logic             ldr_gnt_out;
    logic [15:0]      ldr_a_in;
    logic             ldr_r_nw_in;
    logic [7:0]       ldr_d_in;
    logic [7:0]       ldr_d_out;
    logic [7:0]       mem_d_in;
    logic [15:0]      mem_a_out;
    logic             mem_r_nw_out;
    logic [7:0]       mem_d_out;
    logic [1:0]       owner_out;
    logic [CNT_W-1:0] stall_cnt_out;

    cpumc_bus_arbiter #(
        .LDR_MAX_CYCLES(LDR_MAX),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .cpu_a_in     (cpu_a_in),
        .cpu_r_nw_in  (cpu_r_nw_in),
        .cpu_d_in     (cpu_d_in),
        .cpu_d_out    (cpu_d_out),
        .cpu_rdy_out  (cpu_rdy_out),
        .hci_req_in   (hci_req_in),
        .hci_gnt_out  (hci_gnt_out),
        .hci_a_in     (hci_a_in),
        .hci_r_nw_in  (hci_r_nw_in),
        .hci_d_in     (hci_d_in),
        .hci_d_out    (hci_d_out),
        .ldr_req_in   (ldr_req_in),
        .ldr_gnt_out  (ldr_gnt_out),
        .ldr_a_in     (ldr_a_in),
        .ldr_r_nw_in  (ldr_r_nw_in),
        .ldr_d_in     (ldr_d_in),
        .ldr_d_out    (ldr_d_out),
        .mem_d_in     (mem_d_in),
        .mem_a_out    (mem_a_out),
        .mem_r_nw_out (mem_r_nw_out),
        .mem_d_out    (mem_d_out),
        .owner_out    (owner_out),
        .stall_cnt_out(stall_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: who owns the bus (0 CPU, 1 HCI, 2 LDR, 3 turnaround),
    // how long hci has been kept waiting by the loader, and total CPU stall cycles.
    int m_owner = 0;
    int m_wait  = 0;
    int m_stall = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        logic [15:0] e_a;
        logic        e_rnw;
        logic [7:0]  e_d;
        int          e_stall;
        case (m_owner)
            0:       begin e_a = cpu_a_in; e_rnw = cpu_r_nw_in; e_d = cpu_d_in; end
            1:       begin e_a = hci_a_in; e_rnw = hci_r_nw_in; e_d = hci_d_in; end
            2:       begin e_a = ldr_a_in; e_rnw = ldr_r_nw_in; e_d = ldr_d_in; end
            default: begin e_a = 16'h0000; e_rnw = 1'b1; e_d = 8'h00; end
        endcase
`ifdef CPUMC_ARB_STATS_EN
        e_stall = m_stall;
`else
        e_stall = 0;
`endif
        check("owner",   32'(owner_out),    32'(m_owner));
        check("rdy",     32'(cpu_rdy_out),  32'(m_owner == 0));
        check("hci_gnt", 32'(hci_gnt_out),  32'(m_owner == 1));
        check("ldr_gnt", 32'(ldr_gnt_out),  32'(m_owner == 2));
        check("mem_a",   32'(mem_a_out),    32'(e_a));
        check("mem_rnw", 32'(mem_r_nw_out), 32'(e_rnw));
        check("mem_d",   32'(mem_d_out),    32'(e_d));
        check("cpu_d",   32'(cpu_d_out),    (m_owner == 0) ? 32'(mem_d_in) : 32'h0);
        check("hci_d",   32'(hci_d_out),    (m_owner == 1) ? 32'(mem_d_in) : 32'h0);
        check("ldr_d",   32'(ldr_d_out),    (m_owner == 2) ? 32'(mem_d_in) : 32'h0);
        check("stall",   32'(stall_cnt_out), 32'(e_stall));
    endtask

    task automatic model_clock();
        int nxt;
        nxt = m_owner;
        if (m_owner != 0 && m_stall < STALL_MAX) m_stall++;
        case (m_owner)
            0: if (hci_req_in || ldr_req_in) nxt = 3;
            3: nxt = hci_req_in ? 1 : (ldr_req_in ? 2 : 0);
            1: if (!hci_req_in) nxt = 3;
            default: begin
                if (!ldr_req_in) begin
                    nxt = 3;
                end else if (hci_req_in) begin
                    // Loader may hold the bus for LDR_MAX cycles of hci waiting, no more.
                    m_wait++;
                    if (m_wait >= LDR_MAX) nxt = 3;
                end else begin
                    m_wait = 0;
                end
            end
        endcase
        if (nxt != 2) m_wait = 0;
        m_owner = nxt;
    endtask

    // One bus cycle: new data at negedge, compare, then the model follows the edge.
    task automatic step(input logic h, input logic l);
        @(negedge clk_in);
        cyc++;
        hci_req_in  = h;
        ldr_req_in  = l;
        cpu_a_in    = 16'($urandom);
        cpu_r_nw_in = 1'($urandom);
        cpu_d_in    = 8'($urandom);
        hci_a_in    = 16'($urandom);
        hci_r_nw_in = 1'($urandom);
        hci_d_in    = 8'($urandom);
        ldr_a_in    = 16'($urandom);
        ldr_r_nw_in = 1'($urandom);
        ldr_d_in    = 8'($urandom);
        mem_d_in    = 8'($urandom);
        #1;
        compare_all();
        @(posedge clk_in);
        model_clock();
    endtask

    task automatic async_reset();
        @(negedge clk_in);
        #2;
        rst_in = 1'b1;
        #1;
        check("rst_owner", 32'(owner_out),     32'h0);
        check("rst_rdy",   32'(cpu_rdy_out),   32'h1);
        check("rst_hgnt",  32'(hci_gnt_out),   32'h0);
        check("rst_lgnt",  32'(ldr_gnt_out),   32'h0);
        check("rst_stall", 32'(stall_cnt_out), 32'h0);
        hci_req_in = 1'b0;
        ldr_req_in = 1'b0;
        m_owner = 0;
        m_wait  = 0;
        m_stall = 0;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        logic h_lvl;
        logic l_lvl;
        rst_in      = 1'b1;
        hci_req_in  = 1'b0;
        ldr_req_in  = 1'b0;
        cpu_a_in    = 16'h8000;
        cpu_r_nw_in = 1'b1;
        cpu_d_in    = 8'h00;
        hci_a_in    = 16'h0300;
        hci_r_nw_in = 1'b0;
        hci_d_in    = 8'hA5;
        ldr_a_in    = 16'h0000;
        ldr_r_nw_in = 1'b1;
        ldr_d_in    = 8'h00;
        mem_d_in    = 8'h00;
        #1;
        check("reset_owner", 32'(owner_out),   32'h0);
        check("reset_rdy",   32'(cpu_rdy_out), 32'h1);
        check("reset_mem_a", 32'(mem_a_out),   32'h8000);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;

        repeat (100) step(1'b0, 1'b0);

        // hci session: TURN one cycle after the request, grant the cycle after that.
        step(1'b1, 1'b0);
        #1 check("hci_turn", 32'(owner_out), 32'h3);
        step(1'b1, 1'b0);
        #1 check("hci_gnt_lat", 32'(hci_gnt_out), 32'h1);
        repeat (7) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        #1 check("hci_rel_turn", 32'(owner_out), 32'h3);
        step(1'b0, 1'b0);
        #1 check("hci_rel_rdy", 32'(cpu_rdy_out), 32'h1);

        // Simultaneous requests: hci first, loader straight after without the CPU.
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        #1 check("both_hci_first", 32'(hci_gnt_out), 32'h1);
        repeat (6) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        #1 check("both_turn", 32'(owner_out), 32'h3);
        step(1'b0, 1'b1);
        #1 check("both_ldr_gnt", 32'(ldr_gnt_out), 32'h1);

        // Loader tenure bound while hci waits.
        repeat (LDR_MAX - 1) step(1'b1, 1'b1);
        #1 check("ten_hold", 32'(ldr_gnt_out), 32'h1);
        step(1'b1, 1'b1);
        #1 check("ten_force", 32'(owner_out), 32'h3);
        step(1'b1, 1'b1);
        #1 check("ten_hci_gnt", 32'(hci_gnt_out), 32'h1);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        #1 check("ten_ldr_regnt", 32'(ldr_gnt_out), 32'h1);
        repeat (4) step(1'b0, 1'b0);

        // Long hci hold drives the stall count into saturation.
        repeat (30) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b0);

        // Asynchronous reset in the middle of an hci tenure.
        repeat (4) step(1'b1, 1'b0);
        async_reset();
        repeat (3) step(1'b0, 1'b0);

        h_lvl = 1'b0;
        l_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) h_lvl = ~h_lvl;
            if ($urandom_range(0, 5) == 0) l_lvl = ~l_lvl;
            step(h_lvl, l_lvl);
            if (i == 1500) begin
                async_reset();
                h_lvl = 1'b0;
                l_lvl = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
